// File: rtl/elevator_ctrl.sv
// elevator_ctrl: collective (SCAN) elevator car controller. Latches hall and car
// calls per floor, serves them with door dwell/hold and per-floor travel timing.

module elevator_floor_req (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] i_set,   // {in, down, up}
  input  logic [2:0] i_clr,
  output logic [2:0] o_pend
);
  logic [2:0] r_pend;

  // Serving a floor beats a press landing on the same edge.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_pend <= '0;
    else          r_pend <= (r_pend | i_set) & ~i_clr;

  assign o_pend = r_pend;
endmodule

module elevator_ctrl #(
  parameter int FLOORS        = 4,
  parameter int POS_W         = 3,
  parameter int DOOR_CYCLES   = 2,
  parameter int TRAVEL_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [FLOORS-2:0] button_up,
  input  logic [FLOORS-2:0] button_down,
  input  logic [FLOORS-1:0] button_in,
  input  logic              door_hold,
  output logic [POS_W-1:0]  position,
  output logic              open,
  output logic [1:0]        direction,
  output logic [FLOORS-1:0] req_lamp
);
  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  localparam logic [1:0]        DIR_NONE = 2'b00;
  localparam logic [1:0]        DIR_UP   = 2'b01;
  localparam logic [1:0]        DIR_DN   = 2'b10;
  localparam logic [7:0]        DOOR_LD  = 8'(DOOR_CYCLES);
  localparam logic [7:0]        TRAV_LD  = 8'(TRAVEL_CYCLES);
  localparam logic [FLOORS-1:0] ONE      = 1;

  state_t           r_state, w_state_nx;
  logic [POS_W-1:0] r_pos, w_pos_nx;
  logic [1:0]       r_dir, w_dir_nx;
  logic             r_open, w_open_nx;
  logic [7:0]       r_cnt, w_cnt_nx;

  logic [FLOORS-1:0][2:0] w_set, w_clr, w_pq;
  logic [FLOORS-1:0] w_up, w_dn, w_in, w_pend;
  logic [FLOORS-1:0] w_bup, w_bdn;
  logic [FLOORS-1:0] w_clr_up, w_clr_dn, w_clr_in;
  logic [FLOORS-1:0] w_cons_up, w_cons_dn, w_cons_in;
  logic [FLOORS-1:0] w_here, w_nf_oh;
  logic [POS_W-1:0]  w_nf;
  logic w_door, w_cons_any, w_here_pend, w_above_here, w_below_here;
  logic w_ahead, w_behind, w_stop, w_door_up, w_door_dn;

  function automatic logic any_above(input logic [FLOORS-1:0] v, input logic [POS_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) if (i > int'(f) && v[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] v, input logic [POS_W-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) if (i < int'(f) && v[i]) r = 1'b1;
    return r;
  endfunction

  // Per-floor request latches
  assign w_bup = {1'b0, button_up};
  assign w_bdn = {button_down, 1'b0};

  generate
    for (genvar f = 0; f < FLOORS; f++) begin : g_floor
      assign w_set[f] = {button_in[f] & ~w_cons_in[f],
                         w_bdn[f]     & ~w_cons_dn[f],
                         w_bup[f]     & ~w_cons_up[f]};
      assign w_clr[f] = {w_clr_in[f], w_clr_dn[f], w_clr_up[f]};
      assign w_up[f]  = w_pq[f][0];
      assign w_dn[f]  = w_pq[f][1];
      assign w_in[f]  = w_pq[f][2];

      elevator_floor_req u_req (
        .clk     (clk),
        .reset_n (reset_n),
        .i_set   (w_set[f]),
        .i_clr   (w_clr[f]),
        .o_pend  (w_pq[f])
      );
    end
  endgenerate

  assign w_pend       = w_up | w_dn | w_in;
  assign w_here       = ONE << r_pos;
  assign w_here_pend  = |(w_pend & w_here);
  assign w_above_here = any_above(w_pend, r_pos);
  assign w_below_here = any_below(w_pend, r_pos);

  // Presses at the open floor that agree with travel are absorbed by the dwell.
  assign w_door     = (r_state == S_DOOR);
  assign w_cons_in  = {FLOORS{w_door}} & w_here & button_in;
  assign w_cons_up  = {FLOORS{w_door && r_dir != DIR_DN}} & w_here & w_bup;
  assign w_cons_dn  = {FLOORS{w_door && r_dir != DIR_UP}} & w_here & w_bdn;
  assign w_cons_any = |(w_cons_in | w_cons_up | w_cons_dn);

  // Arrival floor and stop decision for the current move step
  assign w_nf     = (r_dir == DIR_UP) ? r_pos + 1'b1 : r_pos - 1'b1;
  assign w_nf_oh  = ONE << w_nf;
  assign w_ahead  = (r_dir == DIR_UP) ? any_above(w_pend, w_nf) : any_below(w_pend, w_nf);
  assign w_behind = (r_dir == DIR_UP) ? any_below(w_pend, w_nf) : any_above(w_pend, w_nf);
  assign w_stop   = (|(w_nf_oh & (w_in | ((r_dir == DIR_UP) ? w_up : w_dn)))) | !w_ahead;

  // Door close: keep heading if work remains ahead, else fall back to idle rules.
  assign w_door_up = (r_dir == DIR_UP && w_above_here) ||
                     (!(r_dir == DIR_DN && w_below_here) && !w_here_pend && w_above_here);
  assign w_door_dn = !w_door_up &&
                     ((r_dir == DIR_DN && w_below_here) || (!w_here_pend && w_below_here));

  always_comb begin
    w_state_nx = r_state;
    w_pos_nx   = r_pos;
    w_dir_nx   = r_dir;
    w_open_nx  = r_open;
    w_cnt_nx   = r_cnt;
    w_clr_up   = '0;
    w_clr_dn   = '0;
    w_clr_in   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_here_pend) begin
          w_state_nx = S_DOOR;
          w_open_nx  = 1'b1;
          w_dir_nx   = DIR_NONE;
          w_cnt_nx   = DOOR_LD;
          w_clr_up   = w_here;
          w_clr_dn   = w_here;
          w_clr_in   = w_here;
        end else if (w_above_here) begin
          w_state_nx = S_MOVE;
          w_dir_nx   = DIR_UP;
          w_cnt_nx   = TRAV_LD;
        end else if (w_below_here) begin
          w_state_nx = S_MOVE;
          w_dir_nx   = DIR_DN;
          w_cnt_nx   = TRAV_LD;
        end
      end
      S_MOVE: begin
        if (r_cnt > 8'd1) begin
          w_cnt_nx = r_cnt - 8'd1;
        end else begin
          w_pos_nx = w_nf;
          if (w_stop) begin
            w_state_nx = S_DOOR;
            w_open_nx  = 1'b1;
            w_cnt_nx   = DOOR_LD;
            w_clr_in   = w_nf_oh;
            if (r_dir == DIR_UP) w_clr_up = w_nf_oh;
            else                 w_clr_dn = w_nf_oh;
            if (!w_ahead) begin
              w_clr_up = w_nf_oh;
              w_clr_dn = w_nf_oh;
              w_dir_nx = !w_behind          ? DIR_NONE :
                         (r_dir == DIR_UP) ? DIR_DN : DIR_UP;
            end
          end else begin
            w_cnt_nx = TRAV_LD;
          end
        end
      end
      S_DOOR: begin
        if (door_hold || w_cons_any) begin
          w_cnt_nx = DOOR_LD;
        end else if (r_cnt > 8'd1) begin
          w_cnt_nx = r_cnt - 8'd1;
        end else begin
          w_open_nx = 1'b0;
          if (w_door_up) begin
            w_state_nx = S_MOVE;
            w_dir_nx   = DIR_UP;
            w_cnt_nx   = TRAV_LD;
          end else if (w_door_dn) begin
            w_state_nx = S_MOVE;
            w_dir_nx   = DIR_DN;
            w_cnt_nx   = TRAV_LD;
          end else begin
            w_state_nx = S_IDLE;
            w_dir_nx   = DIR_NONE;
            w_cnt_nx   = '0;
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_dir_nx   = DIR_NONE;
        w_open_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_pos   <= '0;
      r_dir   <= DIR_NONE;
      r_open  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pos   <= w_pos_nx;
      r_dir   <= w_dir_nx;
      r_open  <= w_open_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  assign position  = r_pos;
  assign open      = r_open;
  assign direction = r_dir;
  assign req_lamp  = w_pend;
endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl (FLOORS=4, DOOR_CYCLES=2, TRAVEL_CYCLES=1).

module tb_elevator_ctrl;
  logic       clk;
  logic       reset_n;
  logic [2:0] button_up;
  logic [2:0] button_down;
  logic [3:0] button_in;
  logic       door_hold;
  logic [2:0] position;
  logic       open;
  logic [1:0] direction;
  logic [3:0] req_lamp;

  int errors = 0;
  int checks = 0;

  elevator_ctrl #(
    .FLOORS(4), .POS_W(3), .DOOR_CYCLES(2), .TRAVEL_CYCLES(1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .button_up   (button_up),
    .button_down (button_down),
    .button_in   (button_in),
    .door_hold   (door_hold),
    .position    (position),
    .open        (open),
    .direction   (direction),
    .req_lamp    (req_lamp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    button_up = '0; button_down = '0; button_in = '0; door_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    button_up = '0; button_down = '0; button_in = '0; door_hold = 1'b0;
    #1;
    checks++; if (position !== 3'd0) begin errors++; $display("FAIL reset_pos: got %0d want 0", position); end
    checks++; if (open !== 1'b0) begin errors++; $display("FAIL reset_open: got %b want 0", open); end
    checks++; if (direction !== 2'b00) begin errors++; $display("FAIL reset_dir: got %b want 00", direction); end
    checks++; if (req_lamp !== 4'b0000) begin errors++; $display("FAIL reset_lamp: got %b want 0000", req_lamp); end
  endtask

  task automatic test_reset_midtravel;
    do_reset();
    button_in = 4'b1000; tick(); button_in = '0;
    tick(); tick(); tick();
    checks++; if (position !== 3'd2 || direction !== 2'b01) begin errors++; $display("FAIL mid_pre: got pos %0d dir %b want 2 01", position, direction); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (position !== 3'd0) begin errors++; $display("FAIL mid_pos: got %0d want 0", position); end
    checks++; if (open !== 1'b0 || direction !== 2'b00) begin errors++; $display("FAIL mid_od: got open %b dir %b want 0 00", open, direction); end
    checks++; if (req_lamp !== 4'b0000) begin errors++; $display("FAIL mid_lamp: got %b want 0000", req_lamp); end
    #2 reset_n = 1'b1;
    tick(); tick();
    checks++; if (direction !== 2'b00 || position !== 3'd0) begin errors++; $display("FAIL mid_stay: got pos %0d dir %b want 0 00", position, direction); end
  endtask

  task automatic test_call_here;
    do_reset();
    button_up = 3'b001; tick(); button_up = '0;
    checks++; if (req_lamp !== 4'b0001 || open !== 1'b0) begin errors++; $display("FAIL here_k: got lamp %b open %b want 0001 0", req_lamp, open); end
    tick();
    checks++; if (open !== 1'b1 || direction !== 2'b00) begin errors++; $display("FAIL here_k1: got open %b dir %b want 1 00", open, direction); end
    checks++; if (req_lamp !== 4'b0000) begin errors++; $display("FAIL here_lamp_k1: got %b want 0000", req_lamp); end
    tick();
    checks++; if (open !== 1'b1) begin errors++; $display("FAIL here_k2: got open %b want 1", open); end
    tick();
    checks++; if (open !== 1'b0 || direction !== 2'b00) begin errors++; $display("FAIL here_k3: got open %b dir %b want 0 00", open, direction); end
  endtask

  task automatic test_car_call;
    do_reset();
    button_in = 4'b0100; tick(); button_in = '0;
    checks++; if (req_lamp !== 4'b0100) begin errors++; $display("FAIL car_lamp_k: got %b want 0100", req_lamp); end
    tick();
    checks++; if (direction !== 2'b01 || position !== 3'd0) begin errors++; $display("FAIL car_k1: got dir %b pos %0d want 01 0", direction, position); end
    tick();
    checks++; if (position !== 3'd1 || open !== 1'b0) begin errors++; $display("FAIL car_k2: got pos %0d open %b want 1 0", position, open); end
    tick();
    checks++; if (position !== 3'd2 || open !== 1'b1) begin errors++; $display("FAIL car_k3: got pos %0d open %b want 2 1", position, open); end
    checks++; if (req_lamp !== 4'b0000) begin errors++; $display("FAIL car_lamp_k3: got %b want 0000", req_lamp); end
    tick();
    checks++; if (open !== 1'b1) begin errors++; $display("FAIL car_k4: got open %b want 1", open); end
    tick();
    checks++; if (open !== 1'b0 || direction !== 2'b00) begin errors++; $display("FAIL car_k5: got open %b dir %b want 0 00", open, direction); end
  endtask

  task automatic test_down_call_pass;
    do_reset();
    button_down = 3'b010; tick(); button_down = '0;
    checks++; if (req_lamp !== 4'b0100) begin errors++; $display("FAIL dn_lamp_k: got %b want 0100", req_lamp); end
    tick(); tick();
    checks++; if (position !== 3'd1 || open !== 1'b0) begin errors++; $display("FAIL dn_pass1: got pos %0d open %b want 1 0", position, open); end
    tick();
    checks++; if (position !== 3'd2 || open !== 1'b1 || direction !== 2'b00) begin errors++; $display("FAIL dn_k3: got pos %0d open %b dir %b want 2 1 00", position, open, direction); end
    checks++; if (req_lamp !== 4'b0000) begin errors++; $display("FAIL dn_lamp_k3: got %b want 0000", req_lamp); end
  endtask

  task automatic test_door_hold;
    do_reset();
    button_in = 4'b0010; tick(); button_in = '0;
    tick(); tick();
    checks++; if (position !== 3'd1 || open !== 1'b1) begin errors++; $display("FAIL hold_pre: got pos %0d open %b want 1 1", position, open); end
    door_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (open !== 1'b1) begin errors++; $display("FAIL hold_cyc%0d: got open %b want 1", i, open); end
    end
    door_hold = 1'b0;
    tick();
    checks++; if (open !== 1'b1) begin errors++; $display("FAIL hold_after1: got open %b want 1", open); end
    tick();
    checks++; if (open !== 1'b0 || position !== 3'd1) begin errors++; $display("FAIL hold_close: got open %b pos %0d want 0 1", open, position); end
  endtask

  task automatic test_reverse;
    do_reset();
    button_in = 4'b1000; tick(); button_in = '0;
    button_down = 3'b001; tick(); button_down = '0;
    checks++; if (direction !== 2'b01 || req_lamp !== 4'b1010) begin errors++; $display("FAIL rev_k: got dir %b lamp %b want 01 1010", direction, req_lamp); end
    tick();
    checks++; if (position !== 3'd1 || open !== 1'b0) begin errors++; $display("FAIL rev_pass1: got pos %0d open %b want 1 0", position, open); end
    tick(); tick();
    checks++; if (position !== 3'd3 || open !== 1'b1 || direction !== 2'b10) begin errors++; $display("FAIL rev_top: got pos %0d open %b dir %b want 3 1 10", position, open, direction); end
    checks++; if (req_lamp !== 4'b0010) begin errors++; $display("FAIL rev_lamp_top: got %b want 0010", req_lamp); end
    tick(); tick();
    checks++; if (open !== 1'b0 || position !== 3'd3) begin errors++; $display("FAIL rev_close: got open %b pos %0d want 0 3", open, position); end
    tick();
    checks++; if (position !== 3'd2 || open !== 1'b0) begin errors++; $display("FAIL rev_pass2: got pos %0d open %b want 2 0", position, open); end
    tick();
    checks++; if (position !== 3'd1 || open !== 1'b1 || direction !== 2'b00) begin errors++; $display("FAIL rev_arr1: got pos %0d open %b dir %b want 1 1 00", position, open, direction); end
    checks++; if (req_lamp !== 4'b0000) begin errors++; $display("FAIL rev_lamp_end: got %b want 0000", req_lamp); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    button_up = 3'b001; tick(); button_up = '0;
    tick();
    button_in = 4'b0001; tick(); button_in = '0;
    checks++; if (req_lamp !== 4'b0000 || open !== 1'b1) begin errors++; $display("FAIL b2b_consume: got lamp %b open %b want 0000 1", req_lamp, open); end
    tick();
    checks++; if (open !== 1'b1) begin errors++; $display("FAIL b2b_extend: got open %b want 1", open); end
    tick();
    checks++; if (open !== 1'b0 || direction !== 2'b00) begin errors++; $display("FAIL b2b_close: got open %b dir %b want 0 00", open, direction); end
    tick();
    checks++; if (open !== 1'b0 || req_lamp !== 4'b0000) begin errors++; $display("FAIL b2b_noreopen: got open %b lamp %b want 0 0000", open, req_lamp); end
  endtask

  initial begin
    test_reset();
    test_call_here();
    test_car_call();
    test_down_call_pass();
    test_door_hold();
    test_reverse();
    test_back_to_back();
    test_reset_midtravel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
